// File: rtl/lcd_scan_ctrl_pkg.sv
// Shared definitions for the LCD raster sequencer.
//  - default 800x480 panel timing (used as parameter defaults by lcd_scan_ctrl)
//  - scan FSM state encoding
//  - clogb2(): number of bits needed to represent a value
package lcd_scan_ctrl_pkg;

  localparam int DEF_COL_MAX = 800;
  localparam int DEF_FIL_MAX = 480;
  localparam int DEF_H_SYNC  = 1;
  localparam int DEF_H_BACK  = 45;
  localparam int DEF_H_FRONT = 210;
  localparam int DEF_V_SYNC  = 1;
  localparam int DEF_V_BACK  = 22;
  localparam int DEF_V_FRONT = 22;
  localparam int DEF_CLK_DIV = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } scan_state_e;

  // Bits needed to hold 'value' (clogb2(799)=10, clogb2(2)=2, clogb2(1)=1).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    for (r = 0; v > 0; r++) v = v >> 1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_pix_clk_div.sv
// Pixel clock divider.
//  CLK   in  system clock
//  RST_n in  async active-low reset
//  NCLK  out pixel clock, high for counts >= clk_div/2 (50% duty), registered
//  tick  out 1-CLK pulse at count clk_div-1, the CLK before NCLK falls
module lcd_pix_clk_div
  import lcd_scan_ctrl_pkg::*;
#(
  parameter int clk_div = DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic RST_n,
  output logic NCLK,
  output logic tick
);

  localparam int DW = clogb2(clk_div - 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(clk_div - 1);
  localparam logic [DW-1:0] CNT_HALF = DW'(clk_div / 2);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          nclk_q, nclk_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + DW'(1);
    // NCLK follows the next count so it is a clean flop output
    nclk_d = (cnt_d >= CNT_HALF);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q  <= '0;
      nclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      nclk_q <= nclk_d;
    end
  end

  assign NCLK = nclk_q;
  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/lcd_scan_ctrl.sv
// Raster sequencer for a parallel-RGB LCD.
//  CLK, RST_n          system clock, async active-low reset
//  enable              scan request, acted on only at frame boundaries
//  NCLK                pixel clock (CLK / clk_div)
//  DEN, HD, VD         data enable, active-low h/v sync
//  columna, fila       visible pixel address, 0 outside the visible area
//  line_start          1-CLK pulse when a line begins (h_cnt=0)
//  frame_start         1-CLK pulse when a frame begins (h_cnt=0, v_cnt=0)
//  busy                frame in progress (RUN or STOP)
// All raster outputs are registered and change on tick (just before the NCLK
// falling edge), so they are stable at the NCLK rising edge.
module lcd_scan_ctrl
  import lcd_scan_ctrl_pkg::*;
#(
  parameter int col_max_pantalla  = DEF_COL_MAX,
  parameter int fila_max_pantalla = DEF_FIL_MAX,
  parameter int h_sync            = DEF_H_SYNC,
  parameter int h_back            = DEF_H_BACK,
  parameter int h_front           = DEF_H_FRONT,
  parameter int v_sync            = DEF_V_SYNC,
  parameter int v_back            = DEF_V_BACK,
  parameter int v_front           = DEF_V_FRONT,
  parameter int clk_div           = DEF_CLK_DIV,
  parameter int n_col             = clogb2(col_max_pantalla - 1),
  parameter int n_fil             = clogb2(fila_max_pantalla - 1)
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             enable,
  output logic             NCLK,
  output logic             DEN,
  output logic             HD,
  output logic             VD,
  output logic [n_col-1:0] columna,
  output logic [n_fil-1:0] fila,
  output logic             line_start,
  output logic             frame_start,
  output logic             busy
);

  localparam int H_TOTAL = h_sync + h_back + col_max_pantalla + h_front;
  localparam int V_TOTAL = v_sync + v_back + fila_max_pantalla + v_front;
  localparam int HW      = clogb2(H_TOTAL - 1);
  localparam int VW      = clogb2(V_TOTAL - 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC = HW'(h_sync);
  localparam logic [HW-1:0] H_A0   = HW'(h_sync + h_back);
  localparam logic [HW-1:0] H_A1   = HW'(h_sync + h_back + col_max_pantalla);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC = VW'(v_sync);
  localparam logic [VW-1:0] V_A0   = VW'(v_sync + v_back);
  localparam logic [VW-1:0] V_A1   = VW'(v_sync + v_back + fila_max_pantalla);

  logic tick;

  lcd_pix_clk_div #(.clk_div(clk_div)) u_clk_div (
    .CLK   (CLK),
    .RST_n (RST_n),
    .NCLK  (NCLK),
    .tick  (tick)
  );

  scan_state_e      state_q, state_d;
  logic [HW-1:0]    h_cnt_q, h_cnt_d;
  logic [VW-1:0]    v_cnt_q, v_cnt_d;
  logic             den_q, den_d;
  logic             hd_q, hd_d;
  logic             vd_q, vd_d;
  logic [n_col-1:0] col_q, col_d;
  logic [n_fil-1:0] fil_q, fil_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             run_d;
  logic             frame_last;

  assign frame_last = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    den_d   = den_q;
    hd_d    = hd_q;
    vd_d    = vd_q;
    col_d   = col_q;
    fil_d   = fil_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    run_d   = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // counters already sit at pixel (0,0)
          if (enable) begin
            state_d = ST_RUN;
            fs_d    = 1'b1;
          end
        end
        ST_RUN, ST_STOP: begin
          if (frame_last) begin
            // only a frame boundary decides whether another frame follows
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (enable) begin
              state_d = ST_RUN;
              fs_d    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (h_cnt_q == H_LAST) begin
              h_cnt_d = '0;
              v_cnt_d = v_cnt_q + VW'(1);
            end else begin
              h_cnt_d = h_cnt_q + HW'(1);
            end
            state_d = enable ? ST_RUN : ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      endcase

      // decode the pixel that becomes current on this tick
      run_d = (state_d != ST_IDLE);
      ls_d  = run_d && (h_cnt_d == '0);
      hd_d  = !(run_d && (h_cnt_d < H_SYNC));
      vd_d  = !(run_d && (v_cnt_d < V_SYNC));
      den_d = run_d && (h_cnt_d >= H_A0) && (h_cnt_d < H_A1) &&
              (v_cnt_d >= V_A0) && (v_cnt_d < V_A1);
      col_d = den_d ? n_col'(h_cnt_d - H_A0) : '0;
      fil_d = den_d ? n_fil'(v_cnt_d - V_A0) : '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      den_q   <= 1'b0;
      hd_q    <= 1'b1;
      vd_q    <= 1'b1;
      col_q   <= '0;
      fil_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      den_q   <= den_d;
      hd_q    <= hd_d;
      vd_q    <= vd_d;
      col_q   <= col_d;
      fil_q   <= fil_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  assign DEN         = den_q;
  assign HD          = hd_q;
  assign VD          = vd_q;
  assign columna     = col_q;
  assign fila        = fil_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Bench for lcd_scan_ctrl with reduced timing: 4x3 visible, h 1/1/2, v 1/1/1,
// clk_div 2 -> 8 x 6 pixel frame, 96 CLK per frame.
module tb_lcd_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       enable = 1'b0;
  logic       NCLK, DEN, HD, VD, line_start, frame_start, busy;
  logic [1:0] columna;
  logic [1:0] fila;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [9:0] IDLE_VEC = 10'b00_0011_0000;

  lcd_scan_ctrl #(
    .col_max_pantalla (4), .fila_max_pantalla (3),
    .h_sync (1), .h_back (1), .h_front (2),
    .v_sync (1), .v_back (1), .v_front (1),
    .clk_div (2)
  ) dut (
    .CLK (CLK), .RST_n (RST_n), .enable (enable),
    .NCLK (NCLK), .DEN (DEN), .HD (HD), .VD (VD),
    .columna (columna), .fila (fila),
    .line_start (line_start), .frame_start (frame_start), .busy (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {busy, frame_start, line_start, DEN, HD, VD, fila, columna};
  endfunction

  // Expected outputs k CLKs after a frame_start sample (hand timing: 2 CLK/pixel).
  function automatic logic [9:0] pix_exp(input int k);
    int p, h, v;
    logic den, ls, fs, hd, vd;
    logic [1:0] col, fil;
    p   = k / 2;
    h   = p % 8;
    v   = p / 8;
    den = (h >= 2) && (h < 6) && (v >= 2) && (v < 5);
    col = den ? 2'(h - 2) : 2'd0;
    fil = den ? 2'(v - 2) : 2'd0;
    ls  = (k % 2 == 0) && (h == 0);
    fs  = (k == 0);
    hd  = (h >= 1);
    vd  = (v >= 1);
    return {1'b1, fs, ls, den, hd, vd, fil, col};
  endfunction

  task automatic wait_fs(input string nm);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 4) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "_fs"}, frame_start, 1);
    chk({nm, "_lat"}, (n <= 2), 1);
  endtask

  // Walk one frame from its frame_start sample; nxt says whether a new frame follows.
  task automatic run_frame(input string nm, input int drop_k, input int rise_k, input logic nxt);
    int den_n;
    den_n = 0;
    for (int k = 0; k < 96; k++) begin
      chk($sformatf("%s_k%0d", nm, k), obs_vec(), pix_exp(k));
      if (DEN === 1'b1) den_n++;
      if (k == drop_k) enable = 1'b0;
      if (k == rise_k) enable = 1'b1;
      @(posedge CLK); #1;
    end
    chk({nm, "_den_cnt"}, den_n, 24);
    chk({nm, "_end"}, obs_vec(), nxt ? pix_exp(0) : IDLE_VEC);
  endtask

  initial begin
    logic prev;
    int   quiet;

    // 1: reset, then idle with enable low
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_vec", obs_vec(), IDLE_VEC);
    chk("rst_nclk", NCLK, 0);
    #2 RST_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      prev = NCLK;
      @(posedge CLK); #1;
      chk($sformatf("idle_tog%0d", i), NCLK, !prev);
      chk($sformatf("idle_vec%0d", i), obs_vec(), IDLE_VEC);
    end

    // 2: continuous scan
    enable = 1'b1;
    wait_fs("f1");
    run_frame("f1", -1, -1, 1'b1);

    // 3: drop enable at v_cnt=3, frame completes, then stays idle
    run_frame("f2", 48, -1, 1'b0);
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (frame_start !== 1'b0 || busy !== 1'b0) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // 4: drop in row 1, reassert in row 3 -> seamless next frame
    enable = 1'b1;
    wait_fs("f4");
    run_frame("f4", 20, 60, 1'b1);

    // 5: async reset while DEN is high (pixel h=3, v=2)
    repeat (38) @(posedge CLK);
    #1;
    chk("pre_rst_den", DEN, 1);
    RST_n = 1'b0;
    #1;
    chk("async_rst_vec", obs_vec(), IDLE_VEC);
    chk("async_rst_nclk", NCLK, 0);
    #10 RST_n = 1'b1;
    wait_fs("f5");
    run_frame("f5", -1, -1, 1'b1);

    // drop at the first pixel: the frame still completes in full
    run_frame("f6", 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
